// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: grants the player on turn, writes validated moves into
// the 3x3 board, enforces a per-turn timeout and reports win/draw.
module ttt_game_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        p1_req,
  input  logic [3:0]  p1_cell,
  input  logic        p2_req,
  input  logic [3:0]  p2_cell,
  output logic        player_turn,
  output logic [17:0] board,
  output logic        move_ack,
  output logic        move_err,
  output logic        timeout,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw
);

  typedef enum logic [1:0] {IDLE, WAIT_MOVE, CHECK, GAME_OVER} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit               TMR_EN   = (TIMEOUT_CYCLES != 0);

  state_t           state;
  logic [3:0]       move_cnt;
  logic [TMR_W-1:0] timer;

  logic       cur_req;
  logic [3:0] cur_cell;
  logic [1:0] cur_code;
  logic       cell_free;
  logic [8:0] own;
  logic       line_won;

  // Only the player on turn is ever looked at; in CHECK player_turn still names the mover.
  always_comb begin
    cur_req   = player_turn ? p2_req  : p1_req;
    cur_cell  = player_turn ? p2_cell : p1_cell;
    cur_code  = player_turn ? 2'b10   : 2'b01;
    cell_free = 1'b0;
    for (int i = 0; i < 9; i++) begin
      own[i] = (board[2*i +: 2] == cur_code);
      if (cur_cell == 4'(i)) cell_free = (board[2*i +: 2] == 2'b00);
    end
    line_won = (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
               (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
               (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
               (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      board       <= '0;
      player_turn <= 1'b0;
      move_cnt    <= '0;
      timer       <= '0;
      move_ack    <= 1'b0;
      move_err    <= 1'b0;
      timeout     <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
      draw        <= 1'b0;
    end else begin
      move_ack <= 1'b0;
      move_err <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start) begin
            board       <= '0;
            move_cnt    <= '0;
            timer       <= '0;
            player_turn <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
            draw        <= 1'b0;
            state       <= WAIT_MOVE;
          end
        end
        WAIT_MOVE: begin
          if (cur_req && cur_cell <= 4'd8 && cell_free) begin
            for (int i = 0; i < 9; i++)
              if (cur_cell == 4'(i)) board[2*i +: 2] <= cur_code;
            move_cnt <= move_cnt + 4'd1;
            move_ack <= 1'b1;
            state    <= CHECK;
          end else begin
            if (cur_req) move_err <= 1'b1;
            // Rejected requests still burn turn time.
            if (TMR_EN) begin
              if (timer == TMR_LAST) begin
                timeout     <= 1'b1;
                player_turn <= ~player_turn;
                timer       <= '0;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
        end
        CHECK: begin
          if (line_won) begin
            winner    <= cur_code;
            game_over <= 1'b1;
            state     <= GAME_OVER;
          end else if (move_cnt == 4'd9) begin
            draw      <= 1'b1;
            game_over <= 1'b1;
            state     <= GAME_OVER;
          end else begin
            player_turn <= ~player_turn;
            timer       <= '0;
            state       <= WAIT_MOVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: wins, draw, turn gating, rejects, timeout, reset.
module tb_ttt_game_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        p1_req = 1'b0;
  logic [3:0]  p1_cell = 4'd0;
  logic        p2_req = 1'b0;
  logic [3:0]  p2_cell = 4'd0;
  logic        player_turn;
  logic [17:0] board;
  logic        move_ack, move_err, timeout, game_over, draw;
  logic [1:0]  winner;

  int nchk = 0;
  int nerr = 0;

  ttt_game_ctrl #(.TIMEOUT_CYCLES(8), .TMR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_req(p1_req), .p1_cell(p1_cell), .p2_req(p2_req), .p2_cell(p2_cell),
    .player_turn(player_turn), .board(board), .move_ack(move_ack), .move_err(move_err),
    .timeout(timeout), .game_over(game_over), .winner(winner), .draw(draw)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_turn"}, 32'(player_turn), 32'd0);
    chk({tag, "_board"}, 32'(board), 32'd0);
    chk({tag, "_ack"}, 32'(move_ack), 32'd0);
    chk({tag, "_err"}, 32'(move_err), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout), 32'd0);
    chk({tag, "_over"}, 32'(game_over), 32'd0);
    chk({tag, "_win"}, 32'(winner), 32'd0);
    chk({tag, "_draw"}, 32'(draw), 32'd0);
  endtask

  // Request, expect ack after one edge, then let CHECK run.
  task automatic play(input logic pl, input logic [3:0] c, input string tag);
    if (!pl) begin p1_req = 1'b1; p1_cell = c; end
    else     begin p2_req = 1'b1; p2_cell = c; end
    step();
    chk({tag, "_ack"}, 32'(move_ack), 32'd1);
    p1_req = 1'b0;
    p2_req = 1'b0;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    step(); step();
    all_zero("rst");
    rst = 1'b0;

    // Row 0 win for P1
    do_start();
    chk("t1_turn0", 32'(player_turn), 32'd0);
    play(0, 4'd0, "t1_m1");
    chk("t1_turn1", 32'(player_turn), 32'd1);
    play(1, 4'd3, "t1_m2");
    chk("t1_turn2", 32'(player_turn), 32'd0);
    play(0, 4'd1, "t1_m3");
    play(1, 4'd4, "t1_m4");
    play(0, 4'd2, "t1_m5");
    chk("t1_over", 32'(game_over), 32'd1);
    chk("t1_win", 32'(winner), 32'd1);
    chk("t1_draw", 32'(draw), 32'd0);
    chk("t1_row0", 32'(board[5:0]), 32'h15);
    chk("t1_board", 32'(board), 32'h00295);
    p2_req = 1'b1; p2_cell = 4'd8;
    step();
    chk("t1_ignore_ack", 32'(move_ack), 32'd0);
    chk("t1_ignore_brd", 32'(board), 32'h00295);
    p2_req = 1'b0;

    // Off-turn request ignored; start ignored mid-game
    do_start();
    chk("t2_clr_over", 32'(game_over), 32'd0);
    chk("t2_clr_win", 32'(winner), 32'd0);
    chk("t2_clr_brd", 32'(board), 32'd0);
    play(0, 4'd4, "t2_m1");
    chk("t2_turn", 32'(player_turn), 32'd1);
    p1_req = 1'b1; p1_cell = 4'd5; start = 1'b1;
    step();
    p1_req = 1'b0; start = 1'b0;
    chk("t2_noack", 32'(move_ack), 32'd0);
    chk("t2_noerr", 32'(move_err), 32'd0);
    chk("t2_board", 32'(board), 32'h00100);

    // Rejects: occupied cell, then out-of-range cell
    p2_req = 1'b1; p2_cell = 4'd4;
    step();
    chk("t3_occ_err", 32'(move_err), 32'd1);
    chk("t3_occ_ack", 32'(move_ack), 32'd0);
    chk("t3_occ_turn", 32'(player_turn), 32'd1);
    p2_cell = 4'd9;
    step();
    chk("t3_rng_err", 32'(move_err), 32'd1);
    chk("t3_rng_brd", 32'(board), 32'h00100);
    p2_req = 1'b0;
    step();
    chk("t3_err_clr", 32'(move_err), 32'd0);
    // Both request: only P2 (on turn) is served
    p1_req = 1'b1; p1_cell = 4'd1;
    play(1, 4'd0, "t3_both");
    chk("t3_both_brd", 32'(board), 32'h00102);
    chk("t3_both_turn", 32'(player_turn), 32'd0);

    // Reset while in CHECK
    p1_req = 1'b1; p1_cell = 4'd1;
    step();
    p1_req = 1'b0;
    chk("t6_ack", 32'(move_ack), 32'd1);
    rst = 1'b1;
    #1;
    all_zero("t6_rst");
    #2 rst = 1'b0;
    do_start();
    chk("t6_brd", 32'(board), 32'd0);
    chk("t6_turn", 32'(player_turn), 32'd0);

    // Timeout after 8 idle WAIT_MOVE cycles, twice
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t5_pre1", 32'(timeout), 32'd0);
    end
    step();
    chk("t5_tmo1", 32'(timeout), 32'd1);
    chk("t5_turn1", 32'(player_turn), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t5_pre2", 32'(timeout), 32'd0);
    end
    step();
    chk("t5_tmo2", 32'(timeout), 32'd1);
    chk("t5_turn2", 32'(player_turn), 32'd0);

    // Full-board draw
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_start();
    play(0, 4'd0, "t4_m1");
    play(1, 4'd1, "t4_m2");
    play(0, 4'd2, "t4_m3");
    play(1, 4'd4, "t4_m4");
    play(0, 4'd3, "t4_m5");
    play(1, 4'd5, "t4_m6");
    play(0, 4'd7, "t4_m7");
    play(1, 4'd6, "t4_m8");
    chk("t4_mid_over", 32'(game_over), 32'd0);
    chk("t4_mid_turn", 32'(player_turn), 32'd0);
    play(0, 4'd8, "t4_m9");
    chk("t4_over", 32'(game_over), 32'd1);
    chk("t4_draw", 32'(draw), 32'd1);
    chk("t4_win", 32'(winner), 32'd0);
    chk("t4_board", 32'(board), 32'h16A59);
    repeat (10) step();
    chk("t4_hold_tmo", 32'(timeout), 32'd0);
    chk("t4_hold_draw", 32'(draw), 32'd1);
    do_start();
    chk("t4_rs_draw", 32'(draw), 32'd0);
    chk("t4_rs_brd", 32'(board), 32'd0);
    chk("t4_rs_turn", 32'(player_turn), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
